// File: rtl/fwd_pkg.sv
// Forwarding unit shared definitions.
// Holds the 2-bit ALU operand-select codes driven on fwd_sel_o of fwd_scoreboard.
package fwd_pkg;

  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_NONE  = 2'b00;
  localparam fwd_sel_t FWD_MEMWB = 2'b01;
  localparam fwd_sel_t FWD_EXMEM = 2'b10;

endpackage

// File: rtl/fwd_sb_cnt.sv
// One scoreboard entry: cycles remaining until a register's pending result becomes forwardable.
// Ports:
//   clk_i     core clock
//   rst_i     asynchronous active-high reset, clears the count
//   load      a producer of this register is issuing this cycle
//   load_val  latency to load (already clamped by the caller)
//   cnt_o     current remaining latency; 0 means no hazard
module fwd_sb_cnt #(
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A new issue overrides the running decrement (youngest producer wins).
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/fwd_scoreboard.sv
// Forwarding and interlock unit for the pipelined core.
// Produces per-source EX/MEM > MEM/WB forwarding selects for the EX-stage operands and a stall
// request for ID while any source register still has a producer that is not yet forwardable.
// Optional build macro: FWD_PERF_CNT_EN adds saturating stall/forward event counters.
// Ports:
//   clk_i, rst_i               clock, asynchronous active-high reset
//   issue_valid_i              instruction moving ID->EX (before stall gating)
//   issue_regwrite_i           issuing instruction writes rd
//   issue_rd_i, issue_lat_i    issuing rd and its extra latency beyond EX
//   flush_i                    kill the instruction in ID
//   id_rs_i, ex_rs_i           packed ID/EX source addresses, src k at [k*REG_AW +: REG_AW]
//   RegWrite_EX_MEM, RDaddr_EX_MEM_i, RegWrite_MEM_WB, RDaddr_MEM_WB_i  downstream writers
//   fwd_sel_o                  per-source operand select, src k at [2k +: 2]
//   stall_o                    hold PC and IF/ID, bubble ID/EX
//   stall_cnt_o, fwd_cnt_o     (FWD_PERF_CNT_EN only) event counters
module fwd_scoreboard
  import fwd_pkg::*;
#(
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned MAX_LAT = 4,
  localparam int unsigned CNT_W  = $clog2(MAX_LAT + 1)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      issue_valid_i,
  input  logic                      issue_regwrite_i,
  input  logic [REG_AW-1:0]         issue_rd_i,
  input  logic [CNT_W-1:0]          issue_lat_i,
  input  logic                      flush_i,
  input  logic [NUM_SRC*REG_AW-1:0] id_rs_i,
  input  logic [NUM_SRC*REG_AW-1:0] ex_rs_i,
  input  logic                      RegWrite_EX_MEM,
  input  logic [REG_AW-1:0]         RDaddr_EX_MEM_i,
  input  logic                      RegWrite_MEM_WB,
  input  logic [REG_AW-1:0]         RDaddr_MEM_WB_i,
  output logic [NUM_SRC*2-1:0]      fwd_sel_o,
  output logic                      stall_o
`ifdef FWD_PERF_CNT_EN
  ,
  output logic [31:0]               stall_cnt_o,
  output logic [31:0]               fwd_cnt_o
`endif
);

  localparam int unsigned NUM_REGS = 2 ** REG_AW;
  localparam logic [CNT_W-1:0] MaxLatC = CNT_W'(MAX_LAT);

  logic [CNT_W-1:0]  cnt [NUM_REGS];
  logic [REG_AW-1:0] id_rs [NUM_SRC];
  logic [REG_AW-1:0] ex_rs [NUM_SRC];
  logic              issue_fire;
  logic [CNT_W-1:0]  lat_clamped;
  logic              fwd_any;

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_unpack
    assign id_rs[k] = id_rs_i[k*REG_AW +: REG_AW];
    assign ex_rs[k] = ex_rs_i[k*REG_AW +: REG_AW];
  end

  // A stalled or flushed ID instruction never reaches EX, so it must not mark its rd pending.
  assign issue_fire  = issue_valid_i & ~stall_o & ~flush_i;
  assign lat_clamped = (issue_lat_i > MaxLatC) ? MaxLatC : issue_lat_i;

  assign cnt[0] = '0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_sb
    logic load;
    assign load = issue_fire & issue_regwrite_i & (issue_rd_i == REG_AW'(r));

    fwd_sb_cnt #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .load     (load),
      .load_val (lat_clamped),
      .cnt_o    (cnt[r])
    );
  end

  always_comb begin
    stall_o = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if ((id_rs[k] != '0) && (cnt[id_rs[k]] != '0)) begin
        stall_o = 1'b1;
      end
    end
  end

  // EX/MEM holds the younger result, so it takes priority over MEM/WB.
  always_comb begin
    fwd_sel_o = '0;
    fwd_any   = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      fwd_sel_t sel;
      sel = FWD_NONE;
      if (RegWrite_EX_MEM && (RDaddr_EX_MEM_i != '0) && (RDaddr_EX_MEM_i == ex_rs[k])) begin
        sel = FWD_EXMEM;
      end else if (RegWrite_MEM_WB && (RDaddr_MEM_WB_i != '0) &&
                   (RDaddr_MEM_WB_i == ex_rs[k])) begin
        sel = FWD_MEMWB;
      end
      if (rst_i) begin
        sel = FWD_NONE;
      end
      fwd_sel_o[2*k +: 2] = sel;
      if (sel != FWD_NONE) begin
        fwd_any = 1'b1;
      end
    end
  end

`ifdef FWD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, fwd_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      if (stall_o && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (fwd_any && (fwd_cnt_q != '1)) begin
        fwd_cnt_q <= fwd_cnt_q + 32'd1;
      end
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign fwd_cnt_o   = fwd_cnt_q;
`else
  logic unused_fwd_any;
  assign unused_fwd_any = fwd_any;
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
module tb_fwd_scoreboard;

  localparam int unsigned NumSrc = 3;
  localparam int unsigned RegAw  = 5;
  localparam int unsigned CntW   = 3;

  logic                     clk_i;
  logic                     rst_i;
  logic                     issue_valid_i;
  logic                     issue_regwrite_i;
  logic [RegAw-1:0]         issue_rd_i;
  logic [CntW-1:0]          issue_lat_i;
  logic                     flush_i;
  logic [NumSrc*RegAw-1:0]  id_rs_i;
  logic [NumSrc*RegAw-1:0]  ex_rs_i;
  logic                     RegWrite_EX_MEM;
  logic [RegAw-1:0]         RDaddr_EX_MEM_i;
  logic                     RegWrite_MEM_WB;
  logic [RegAw-1:0]         RDaddr_MEM_WB_i;
  logic [NumSrc*2-1:0]      fwd_sel_o;
  logic                     stall_o;
`ifdef FWD_PERF_CNT_EN
  logic [31:0]              stall_cnt_o;
  logic [31:0]              fwd_cnt_o;
`endif

  int checks;
  int failures;

  fwd_scoreboard #(
    .NUM_SRC (NumSrc),
    .REG_AW  (RegAw),
    .MAX_LAT (4)
  ) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .issue_valid_i    (issue_valid_i),
    .issue_regwrite_i (issue_regwrite_i),
    .issue_rd_i       (issue_rd_i),
    .issue_lat_i      (issue_lat_i),
    .flush_i          (flush_i),
    .id_rs_i          (id_rs_i),
    .ex_rs_i          (ex_rs_i),
    .RegWrite_EX_MEM  (RegWrite_EX_MEM),
    .RDaddr_EX_MEM_i  (RDaddr_EX_MEM_i),
    .RegWrite_MEM_WB  (RegWrite_MEM_WB),
    .RDaddr_MEM_WB_i  (RDaddr_MEM_WB_i),
    .fwd_sel_o        (fwd_sel_o),
    .stall_o          (stall_o)
`ifdef FWD_PERF_CNT_EN
    ,
    .stall_cnt_o      (stall_cnt_o),
    .fwd_cnt_o        (fwd_cnt_o)
`endif
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    issue_valid_i    = 1'b0;
    issue_regwrite_i = 1'b0;
    issue_rd_i       = '0;
    issue_lat_i      = '0;
    flush_i          = 1'b0;
    id_rs_i          = '0;
    ex_rs_i          = '0;
    RegWrite_EX_MEM  = 1'b0;
    RDaddr_EX_MEM_i  = '0;
    RegWrite_MEM_WB  = 1'b0;
    RDaddr_MEM_WB_i  = '0;
  endtask

  // Issue one register-writing instruction across a single clock edge.
  task automatic issue(input logic [RegAw-1:0] rd, input logic [CntW-1:0] lat,
                       input logic flush);
    issue_valid_i    = 1'b1;
    issue_regwrite_i = 1'b1;
    issue_rd_i       = rd;
    issue_lat_i      = lat;
    flush_i          = flush;
    tick();
    issue_valid_i    = 1'b0;
    issue_regwrite_i = 1'b0;
    flush_i          = 1'b0;
  endtask

  // Count consecutive stall cycles starting now, bounded so a stuck stall cannot hang the run.
  task automatic measure_stall(output int n);
    #1;
    n = 0;
    while (stall_o && n < 20) begin
      n++;
      tick();
    end
  endtask

  task automatic test_reset();
    int n;
    logic any_stall;
    rst_i = 1'b1;
    idle();
    RegWrite_EX_MEM = 1'b1;
    RDaddr_EX_MEM_i = 5'd7;
    ex_rs_i         = {5'd0, 5'd0, 5'd7};
    #1;
    checks++;
    if (stall_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_stall: got %b want 0", stall_o);
    end
    checks++;
    if (fwd_sel_o !== 6'b000000) begin
      failures++;
      $display("FAIL reset_fwd_sel: got %b want 000000", fwd_sel_o);
    end
    tick();
    rst_i = 1'b0;
    idle();
    tick();
    issue(5'd5, 3'd3, 1'b0);
    id_rs_i = {5'd0, 5'd0, 5'd5};
    #1;
    checks++;
    if (stall_o !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_stall: got %b want 1", stall_o);
    end
    rst_i = 1'b1;
    #1;
    checks++;
    if (stall_o !== 1'b0) begin
      failures++;
      $display("FAIL async_reset_stall: got %b want 0", stall_o);
    end
    tick();
    rst_i = 1'b0;
    #1;
    any_stall = 1'b0;
    for (int r = 1; r < 32; r++) begin
      id_rs_i = {5'd0, 5'd0, 5'(r)};
      #1;
      if (stall_o !== 1'b0) any_stall = 1'b1;
    end
    checks++;
    if (any_stall !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_clear: got stall on some reg, want none");
    end
    idle();
    measure_stall(n);
  endtask

  task automatic test_load_use();
    int n;
    idle();
    issue(5'd5, 3'd1, 1'b0);
    id_rs_i = {5'd0, 5'd0, 5'd5};
    measure_stall(n);
    checks++;
    if (n != 1) begin
      failures++;
      $display("FAIL load_use_stall_cycles: got %0d want 1", n);
    end
    id_rs_i         = '0;
    ex_rs_i         = {5'd0, 5'd0, 5'd5};
    RegWrite_MEM_WB = 1'b1;
    RDaddr_MEM_WB_i = 5'd5;
    #1;
    checks++;
    if (fwd_sel_o !== 6'b000001) begin
      failures++;
      $display("FAIL load_use_fwd_memwb: got %b want 000001", fwd_sel_o);
    end
    RegWrite_MEM_WB = 1'b0;
    #1;
    checks++;
    if (fwd_sel_o !== 6'b000000) begin
      failures++;
      $display("FAIL memwb_no_regwrite: got %b want 000000", fwd_sel_o);
    end
    idle();
  endtask

  task automatic test_double_hazard();
    idle();
    RegWrite_EX_MEM = 1'b1;
    RDaddr_EX_MEM_i = 5'd7;
    RegWrite_MEM_WB = 1'b1;
    RDaddr_MEM_WB_i = 5'd7;
    ex_rs_i         = {5'd7, 5'd7, 5'd3};
    #1;
    checks++;
    if (fwd_sel_o !== 6'b101000) begin
      failures++;
      $display("FAIL double_hazard_exmem: got %b want 101000", fwd_sel_o);
    end
    RegWrite_EX_MEM = 1'b0;
    #1;
    checks++;
    if (fwd_sel_o !== 6'b010100) begin
      failures++;
      $display("FAIL fallback_memwb: got %b want 010100", fwd_sel_o);
    end
    RegWrite_EX_MEM = 1'b1;
    RDaddr_EX_MEM_i = 5'd0;
    RDaddr_MEM_WB_i = 5'd0;
    ex_rs_i         = {5'd0, 5'd0, 5'd0};
    #1;
    checks++;
    if (fwd_sel_o !== 6'b000000) begin
      failures++;
      $display("FAIL x0_no_forward: got %b want 000000", fwd_sel_o);
    end
    idle();
  endtask

  task automatic test_mul();
    int n;
    idle();
    issue(5'd9, 3'd4, 1'b0);
    id_rs_i = {5'd0, 5'd9, 5'd0};
    measure_stall(n);
    checks++;
    if (n != 4) begin
      failures++;
      $display("FAIL mul_lat4_stall: got %0d want 4", n);
    end
    id_rs_i = '0;
    issue(5'd9, 3'd7, 1'b0);
    id_rs_i = {5'd0, 5'd9, 5'd0};
    measure_stall(n);
    checks++;
    if (n != 4) begin
      failures++;
      $display("FAIL lat_clamp_stall: got %0d want 4", n);
    end
    id_rs_i = '0;
    issue(5'd9, 3'd0, 1'b0);
    id_rs_i = {5'd0, 5'd9, 5'd0};
    measure_stall(n);
    checks++;
    if (n != 0) begin
      failures++;
      $display("FAIL alu_lat0_stall: got %0d want 0", n);
    end
    id_rs_i = '0;
    issue(5'd0, 3'd4, 1'b0);
    measure_stall(n);
    checks++;
    if (n != 0) begin
      failures++;
      $display("FAIL x0_never_stalls: got %0d want 0", n);
    end
    idle();
  endtask

  task automatic test_waw();
    int n;
    idle();
    issue(5'd3, 3'd4, 1'b0);
    tick();
    tick();
    issue(5'd3, 3'd1, 1'b0);
    id_rs_i = {5'd0, 5'd0, 5'd3};
    measure_stall(n);
    checks++;
    if (n != 1) begin
      failures++;
      $display("FAIL waw_reload_down: got %0d want 1", n);
    end
    id_rs_i = '0;
    issue(5'd3, 3'd1, 1'b0);
    issue(5'd3, 3'd4, 1'b0);
    id_rs_i = {5'd0, 5'd0, 5'd3};
    measure_stall(n);
    checks++;
    if (n != 4) begin
      failures++;
      $display("FAIL waw_reload_up: got %0d want 4", n);
    end
    id_rs_i = '0;
    issue(5'd3, 3'd4, 1'b1);
    id_rs_i = {5'd0, 5'd0, 5'd3};
    measure_stall(n);
    checks++;
    if (n != 0) begin
      failures++;
      $display("FAIL flush_blocks_issue: got %0d want 0", n);
    end
    // An issue attempt while ID is stalled must not register.
    id_rs_i = '0;
    issue(5'd9, 3'd4, 1'b0);
    id_rs_i = {5'd0, 5'd0, 5'd9};
    issue(5'd3, 3'd4, 1'b0);
    id_rs_i = {5'd0, 5'd0, 5'd3};
    #1;
    checks++;
    if (stall_o !== 1'b0) begin
      failures++;
      $display("FAIL stall_blocks_issue: got %b want 0", stall_o);
    end
    idle();
    repeat (5) tick();
  endtask

  task automatic test_three_src();
    int n;
`ifdef FWD_PERF_CNT_EN
    logic [31:0] before;
`endif
    idle();
    issue(5'd12, 3'd2, 1'b0);
`ifdef FWD_PERF_CNT_EN
    before = stall_cnt_o;
`endif
    id_rs_i = {5'd12, 5'd1, 5'd2};
    #1;
    checks++;
    if (stall_o !== 1'b1) begin
      failures++;
      $display("FAIL src2_stall: got %b want 1", stall_o);
    end
    measure_stall(n);
    checks++;
    if (n != 2) begin
      failures++;
      $display("FAIL src2_stall_cycles: got %0d want 2", n);
    end
`ifdef FWD_PERF_CNT_EN
    checks++;
    if (stall_cnt_o - before !== 32'd2) begin
      failures++;
      $display("FAIL perf_stall_cnt_delta: got %0d want 2", stall_cnt_o - before);
    end
    idle();
    tick();
    before          = fwd_cnt_o;
    RegWrite_MEM_WB = 1'b1;
    RDaddr_MEM_WB_i = 5'd4;
    ex_rs_i         = {5'd4, 5'd0, 5'd0};
    repeat (3) tick();
    checks++;
    if (fwd_cnt_o - before !== 32'd3) begin
      failures++;
      $display("FAIL perf_fwd_cnt_delta: got %0d want 3", fwd_cnt_o - before);
    end
`endif
    idle();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_load_use();
    test_double_hazard();
    test_mul();
    test_waw();
    test_three_src();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
